// File: rtl/store_write_buffer.sv
// store_write_buffer
// Posted-write buffer between the single-cycle datapath's data-memory port
// and a multi-cycle data memory with a req/ack handshake. Stores are queued
// and drained in order. Loads are forwarded from the queue when the word
// matches; otherwise they perform a blocking memory read while stall
// freezes the PC.
//
// Optional build macro: WB_COALESCE_EN
//   When defined, a store that hits the newest matching entry (other than
//   the head being written to memory) overwrites that entry's data in place
//   instead of allocating a new one.

module store_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        cpu_addr,
  input  logic [DATA_W-1:0]        cpu_wdata,
  input  logic                     cpu_we,
  input  logic                     cpu_re,
  output logic [DATA_W-1:0]        cpu_rdata,
  output logic                     stall,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic                     mem_ack,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic                     wb_empty,
  output logic [$clog2(DEPTH):0]   wb_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_t;

  // Queue storage and bookkeeping
  logic [ADDR_W-1:0] addr_mem_r [DEPTH];
  logic [DATA_W-1:0] data_mem_r [DEPTH];
  logic [PW-1:0]     head_r;
  logic [PW-1:0]     tail_r;
  logic [CW-1:0]     count_r;

  // Memory-side FSM and registered port values
  state_t            state_r;
  state_t            state_nxt_s;
  logic              mem_req_r;
  logic              mem_req_nxt_s;
  logic              mem_we_r;
  logic              mem_we_nxt_s;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [ADDR_W-1:0] mem_addr_nxt_s;
  logic [DATA_W-1:0] mem_wdata_r;
  logic [DATA_W-1:0] mem_wdata_nxt_s;

  // Blocking-load capture
  logic              load_done_r;
  logic [DATA_W-1:0] rdata_q_r;

  // Decoded control
  logic              fwd_hit_s;
  logic [DATA_W-1:0] fwd_data_s;
  logic [PW-1:0]     fwd_idx_s;
  logic              full_s;
  logic              load_s;
  logic              pending_miss_s;
  logic              consume_s;
  logic              start_write_s;
  logic              coalesce_s;
  logic              enq_s;
  logic              deq_s;
  logic              rd_done_s;

  assign full_s         = (count_r == CW'(DEPTH));
  assign load_s         = cpu_re && !cpu_we;
  assign pending_miss_s = load_s && !fwd_hit_s && !load_done_r;
  assign consume_s      = load_s && !fwd_hit_s && load_done_r;
  assign start_write_s  = (state_r == ST_IDLE) && !pending_miss_s && (count_r != {CW{1'b0}});

`ifdef WB_COALESCE_EN
  logic head_busy_s;
  // The head is busy once it is in WRITE or is being launched this cycle,
  // because mem_wdata captures its data at the same edge.
  assign head_busy_s = (state_r == ST_WRITE) || start_write_s;
  assign coalesce_s  = cpu_we && fwd_hit_s && !((fwd_idx_s == head_r) && head_busy_s);
`else
  assign coalesce_s  = 1'b0;
`endif

  assign enq_s = cpu_we && !full_s && !coalesce_s;

  // Newest-match search over valid entries, oldest to newest so the last hit wins.
  always_comb begin
    fwd_hit_s  = 1'b0;
    fwd_data_s = {DATA_W{1'b0}};
    fwd_idx_s  = head_r;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count_r) &&
          (addr_mem_r[head_r + PW'(i)][ADDR_W-1:2] == cpu_addr[ADDR_W-1:2])) begin
        fwd_hit_s  = 1'b1;
        fwd_data_s = data_mem_r[head_r + PW'(i)];
        fwd_idx_s  = head_r + PW'(i);
      end else begin
        fwd_hit_s  = fwd_hit_s;
      end
    end
  end

  // Memory FSM next state and next values of the registered memory port.
  always_comb begin
    state_nxt_s     = state_r;
    mem_req_nxt_s   = mem_req_r;
    mem_we_nxt_s    = mem_we_r;
    mem_addr_nxt_s  = mem_addr_r;
    mem_wdata_nxt_s = mem_wdata_r;
    deq_s           = 1'b0;
    rd_done_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pending_miss_s) begin
          state_nxt_s    = ST_READ;
          mem_req_nxt_s  = 1'b1;
          mem_we_nxt_s   = 1'b0;
          mem_addr_nxt_s = cpu_addr;
        end else if (start_write_s) begin
          state_nxt_s     = ST_WRITE;
          mem_req_nxt_s   = 1'b1;
          mem_we_nxt_s    = 1'b1;
          mem_addr_nxt_s  = addr_mem_r[head_r];
          mem_wdata_nxt_s = data_mem_r[head_r];
        end else begin
          mem_req_nxt_s = 1'b0;
          mem_we_nxt_s  = 1'b0;
        end
      end
      ST_WRITE: begin
        if (mem_ack) begin
          state_nxt_s   = ST_IDLE;
          mem_req_nxt_s = 1'b0;
          mem_we_nxt_s  = 1'b0;
          deq_s         = 1'b1;
        end else begin
          state_nxt_s = ST_WRITE;
        end
      end
      ST_READ: begin
        if (mem_ack) begin
          state_nxt_s   = ST_IDLE;
          mem_req_nxt_s = 1'b0;
          rd_done_s     = 1'b1;
        end else begin
          state_nxt_s = ST_READ;
        end
      end
      default: begin
        state_nxt_s   = ST_IDLE;
        mem_req_nxt_s = 1'b0;
        mem_we_nxt_s  = 1'b0;
      end
    endcase
  end

  // FSM state and memory port registers; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      mem_req_r   <= mem_req_nxt_s;
      mem_we_r    <= mem_we_nxt_s;
      mem_addr_r  <= mem_addr_nxt_s;
      mem_wdata_r <= mem_wdata_nxt_s;
    end
  end

  // Store queue: enqueue at tail, coalesce in place, retire head on write ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r  <= {PW{1'b0}};
      tail_r  <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem_r[i] <= {ADDR_W{1'b0}};
        data_mem_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      if (enq_s) begin
        addr_mem_r[tail_r] <= cpu_addr;
        data_mem_r[tail_r] <= cpu_wdata;
        tail_r             <= tail_r + PW'(1'b1);
      end else if (coalesce_s) begin
        data_mem_r[fwd_idx_s] <= cpu_wdata;
      end else begin
        tail_r <= tail_r;
      end
      if (deq_s) begin
        head_r <= head_r + PW'(1'b1);
      end else begin
        head_r <= head_r;
      end
      case ({enq_s, deq_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Blocking-load result: captured on read ack, consumed by the retried load.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_done_r <= 1'b0;
      rdata_q_r   <= {DATA_W{1'b0}};
    end else if (rd_done_s) begin
      load_done_r <= 1'b1;
      rdata_q_r   <= mem_rdata;
    end else if (consume_s) begin
      load_done_r <= 1'b0;
    end else begin
      load_done_r <= load_done_r;
    end
  end

  // CPU-facing results: zero-latency forward, captured load data, and PC stall.
  always_comb begin
    cpu_rdata = {DATA_W{1'b0}};
    stall     = 1'b0;
    if (rst) begin
      stall = 1'b0;
    end else begin
      stall = (cpu_we && full_s && !coalesce_s) || pending_miss_s;
      if (load_s && fwd_hit_s) begin
        cpu_rdata = fwd_data_s;
      end else if (consume_s) begin
        cpu_rdata = rdata_q_r;
      end else begin
        cpu_rdata = {DATA_W{1'b0}};
      end
    end
  end

  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign wb_count  = count_r;
  assign wb_empty  = (count_r == {CW{1'b0}}) && (state_r == ST_IDLE);

endmodule

// File: tb/tb_store_write_buffer.sv
// Directed testbench for store_write_buffer (default build, DEPTH=4).
// Inputs change 1ns after the rising edge; outputs are compared 2ns after it.

module tb_store_write_buffer;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_we;
  logic              cpu_re;
  logic [DATA_W-1:0] cpu_rdata;
  logic              stall;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              wb_empty;
  logic [2:0]        wb_count;

  int errors = 0;
  int checks = 0;

  store_write_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_re(cpu_re),
    .cpu_rdata(cpu_rdata), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_empty(wb_empty), .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (wb_empty !== 1'b1 && w < 40) begin
      mem_ack = (mem_req === 1'b1);
      tick();
      mem_ack = 1'b0;
      #1;
      w++;
    end
    checks++; if (wb_empty !== 1'b1) begin errors++; $display("FAIL drain_timeout: wb_empty=%b required 1", wb_empty); end
  endtask

  task automatic test_reset();
    rst = 1'b1; cpu_we = 1'b1; cpu_re = 1'b0; cpu_addr = 32'h10; cpu_wdata = 32'h1;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    tick(); tick(); #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b required 0", stall); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %b required 0", mem_req); end
    rst = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    tick(); #1;
    checks++; if (wb_empty !== 1'b1) begin errors++; $display("FAIL idle_wb_empty: got %b required 1", wb_empty); end
    checks++; if (wb_count !== 3'd0) begin errors++; $display("FAIL idle_wb_count: got %0d required 0", wb_count); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL idle_stall: got %b required 0", stall); end
    checks++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== 66'h0) begin errors++; $display("FAIL idle_mem_port: req=%b we=%b addr=%h wdata=%h required all 0", mem_req, mem_we, mem_addr, mem_wdata); end
    checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL idle_cpu_rdata: got %h required 0", cpu_rdata); end
  endtask

  task automatic test_single_store();
    tick(); cpu_we = 1'b1; cpu_addr = 32'h100; cpu_wdata = 32'hDEADBEEF; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL store_stall: got %b required 0", stall); end
    tick(); cpu_we = 1'b0; #1;
    checks++; if (wb_count !== 3'd1) begin errors++; $display("FAIL store_count1: got %0d required 1", wb_count); end
    checks++; if (mem_req !== 1'b0 || wb_empty !== 1'b0) begin errors++; $display("FAIL store_c1: mem_req=%b wb_empty=%b required 0 0", mem_req, wb_empty); end
    for (int k = 0; k < 3; k++) begin
      tick(); #1;
      checks++;
      if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'h100, 32'hDEADBEEF}) begin
        errors++; $display("FAIL store_hold%0d: req=%b we=%b addr=%h wdata=%h required 1 1 00000100 deadbeef", k, mem_req, mem_we, mem_addr, mem_wdata);
      end
    end
    tick(); mem_ack = 1'b1; #1;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin errors++; $display("FAIL store_ack_cycle: req=%b addr=%h required 1 00000100", mem_req, mem_addr); end
    tick(); mem_ack = 1'b0; #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL store_req_drop: got %b required 0", mem_req); end
    checks++; if (wb_count !== 3'd0 || wb_empty !== 1'b1) begin errors++; $display("FAIL store_done: count=%0d empty=%b required 0 1", wb_count, wb_empty); end
  endtask

  task automatic test_fill();
    logic [31:0] exp_addr [4];
    logic [31:0] exp_data [4];
    int w;
    exp_addr[0] = 32'h14; exp_addr[1] = 32'h18; exp_addr[2] = 32'h1C; exp_addr[3] = 32'h200;
    exp_data[0] = 32'h2;  exp_data[1] = 32'h3;  exp_data[2] = 32'h4;  exp_data[3] = 32'h55;
    for (int k = 0; k < 4; k++) begin
      tick(); cpu_we = 1'b1; cpu_addr = 32'h10 + 32'(4 * k); cpu_wdata = 32'(k + 1); #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fill_stall%0d: got %b required 0", k, stall); end
    end
    tick(); cpu_addr = 32'h200; cpu_wdata = 32'h55; #1;
    checks++; if (stall !== 1'b1 || wb_count !== 3'd4) begin errors++; $display("FAIL full_stall: stall=%b count=%0d required 1 4", stall, wb_count); end
    checks++; if (mem_addr !== 32'h10 || mem_req !== 1'b1) begin errors++; $display("FAIL full_head: addr=%h req=%b required 00000010 1", mem_addr, mem_req); end
    tick(); #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL full_stall2: got %b required 1", stall); end
    tick(); mem_ack = 1'b1; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL full_stall_on_ack: got %b required 1", stall); end
    tick(); mem_ack = 1'b0; #1;
    checks++; if (wb_count !== 3'd3 || stall !== 1'b0) begin errors++; $display("FAIL full_release: count=%0d stall=%b required 3 0", wb_count, stall); end
    tick(); cpu_we = 1'b0; #1;
    checks++; if (wb_count !== 3'd4) begin errors++; $display("FAIL full_refill: got %0d required 4", wb_count); end
    for (int k = 0; k < 4; k++) begin
      w = 0;
      while (mem_req !== 1'b1 && w < 10) begin tick(); #1; w++; end
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL fill_wait%0d: mem_req=%b required 1", k, mem_req); end
      checks++;
      if ({mem_we, mem_addr, mem_wdata} !== {1'b1, exp_addr[k], exp_data[k]}) begin
        errors++; $display("FAIL fill_order%0d: we=%b addr=%h wdata=%h required 1 %h %h", k, mem_we, mem_addr, mem_wdata, exp_addr[k], exp_data[k]);
      end
      mem_ack = 1'b1; tick(); mem_ack = 1'b0; #1;
    end
    checks++; if (wb_empty !== 1'b1) begin errors++; $display("FAIL fill_empty: got %b required 1", wb_empty); end
  endtask

  task automatic test_forward();
    tick(); cpu_we = 1'b1; cpu_addr = 32'h104; cpu_wdata = 32'h11; #1;
    tick(); cpu_wdata = 32'h22; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fwd_store_stall: got %b required 0", stall); end
    tick(); cpu_we = 1'b0; cpu_re = 1'b1; cpu_addr = 32'h104; #1;
    checks++; if (cpu_rdata !== 32'h22 || stall !== 1'b0) begin errors++; $display("FAIL fwd_newest: rdata=%h stall=%b required 00000022 0", cpu_rdata, stall); end
    checks++; if (wb_count !== 3'd2) begin errors++; $display("FAIL fwd_count: got %0d required 2", wb_count); end
    cpu_addr = 32'h107; #1;
    checks++; if (cpu_rdata !== 32'h22) begin errors++; $display("FAIL fwd_word_gran: got %h required 00000022", cpu_rdata); end
    tick(); cpu_re = 1'b0; #1;
    checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL fwd_idle_rdata: got %h required 0", cpu_rdata); end
    drain();
  endtask

  task automatic test_load_miss();
    tick(); cpu_we = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'h77; #1;
    tick(); cpu_we = 1'b0; #1;
    tick(); cpu_re = 1'b1; cpu_addr = 32'h300; #1;
    checks++; if (stall !== 1'b1 || mem_we !== 1'b1 || mem_req !== 1'b1) begin errors++; $display("FAIL miss_during_write: stall=%b we=%b req=%b required 1 1 1", stall, mem_we, mem_req); end
    tick(); mem_ack = 1'b1; #1;
    checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h40 || stall !== 1'b1) begin errors++; $display("FAIL miss_write_held: we=%b addr=%h stall=%b required 1 00000040 1", mem_we, mem_addr, stall); end
    tick(); mem_ack = 1'b0; #1;
    checks++; if (mem_req !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL miss_gap: req=%b stall=%b required 0 1", mem_req, stall); end
    tick(); #1;
    checks++; if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h300}) begin errors++; $display("FAIL miss_read_issue: req=%b we=%b addr=%h required 1 0 00000300", mem_req, mem_we, mem_addr); end
    tick(); mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D; #1;
    checks++; if (mem_req !== 1'b1 || stall !== 1'b1) begin errors++; $display("FAIL miss_read_hold: req=%b stall=%b required 1 1", mem_req, stall); end
    tick(); mem_ack = 1'b0; mem_rdata = 32'h0; #1;
    checks++; if (stall !== 1'b0 || cpu_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL miss_result: stall=%b rdata=%h required 0 cafef00d", stall, cpu_rdata); end
    tick(); cpu_re = 1'b0; #1;
    checks++; if (cpu_rdata !== 32'h0 || wb_empty !== 1'b1) begin errors++; $display("FAIL miss_after: rdata=%h empty=%b required 0 1", cpu_rdata, wb_empty); end
  endtask

  task automatic test_back_to_back();
    tick(); cpu_we = 1'b1; cpu_addr = 32'h500; cpu_wdata = 32'hA; #1;
    tick(); cpu_we = 1'b0; #1;
    tick(); cpu_we = 1'b1; cpu_addr = 32'h504; cpu_wdata = 32'hB; mem_ack = 1'b1; #1;
    checks++; if (mem_req !== 1'b1 || wb_count !== 3'd1) begin errors++; $display("FAIL b2b_pre: req=%b count=%0d required 1 1", mem_req, wb_count); end
    tick(); cpu_we = 1'b0; mem_ack = 1'b0; #1;
    checks++; if (wb_count !== 3'd1 || mem_req !== 1'b0) begin errors++; $display("FAIL b2b_count: count=%0d req=%b required 1 0", wb_count, mem_req); end
    tick(); #1;
    checks++; if ({mem_req, mem_addr, mem_wdata} !== {1'b1, 32'h504, 32'hB}) begin errors++; $display("FAIL b2b_next: req=%b addr=%h wdata=%h required 1 00000504 0000000b", mem_req, mem_addr, mem_wdata); end
    drain();
  endtask

  task automatic test_reset_mid();
    tick(); cpu_we = 1'b1; cpu_addr = 32'h80; cpu_wdata = 32'h99; #1;
    tick(); cpu_we = 1'b0; #1;
    tick(); rst = 1'b1; #1;
    checks++; if (mem_req !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL rstmid_pre: req=%b stall=%b required 1 0", mem_req, stall); end
    tick(); rst = 1'b0; mem_ack = 1'b1; #1;
    checks++; if (mem_req !== 1'b0 || wb_count !== 3'd0) begin errors++; $display("FAIL rstmid_cleared: req=%b count=%0d required 0 0", mem_req, wb_count); end
    tick(); mem_ack = 1'b0; #1;
    checks++; if (wb_count !== 3'd0 || wb_empty !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL rstmid_late_ack: count=%0d empty=%b req=%b required 0 1 0", wb_count, wb_empty, mem_req); end
    tick(); #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rstmid_quiet: req=%b required 0", mem_req); end
  endtask

  initial begin
    test_reset();
    test_single_store();
    test_fill();
    test_forward();
    test_load_miss();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/store_write_buffer.md
Name: store_write_buffer

Overview:
- Posted-write buffer directly downstream of the single-cycle datapath's ALU/data-memory port.
- Consumes the effective address (ALU result), store data (register read port 2), WriteMem and ReadMem.
- Queues stores and drains them to a multi-cycle data memory over a req/ack handshake.
- Services loads by forwarding from the queue or by a blocking memory read; asserts stall to freeze the PC.

Parameters:
- DEPTH, 4, number of store entries (power of 2, ≥2)
- ADDR_W, 32, address width
- DATA_W, 32, data width (one word per entry)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cpu_addr  in  ADDR_W  effective address from ALU
- cpu_wdata  in  DATA_W  store data
- cpu_we  in  1  store request (WriteMem)
- cpu_re  in  1  load request (ReadMem)
- cpu_rdata  out  DATA_W  load result to MemToReg mux
- stall  out  1  freeze PC/register write this cycle
- mem_req  out  1  memory request valid
- mem_we  out  1  1=write, 0=read
- mem_addr  out  ADDR_W  memory word address
- mem_wdata  out  DATA_W  memory write data
- mem_ack  in  1  one-cycle completion pulse
- mem_rdata  in  DATA_W  read data, valid with mem_ack
- wb_empty  out  1  no pending stores and FSM IDLE
- wb_count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset:
  - Synchronous, active-high on clk; rst is sampled only at the clk edge.
  - Clears head, tail and count; FSM to IDLE; load_done cleared.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rdata=0, wb_empty=1, wb_count=0.
  - While rst is high, stall=0.
  - Reset mid-transaction abandons the memory access; mem_req low the cycle after rst is sampled; late mem_ack is ignored.
- Addressing:
  - Word granularity; compare cpu_addr[ADDR_W-1:2] only.
  - mem_addr carries the full stored address; no byte enables.
- Store (cpu_we=1):
  - If count<DEPTH, enqueue {addr,data} at tail on the clock edge; stall=0.
  - If count==DEPTH, stall=1 and nothing is enqueued, even if the head completes that same cycle. Enqueue happens the first cycle count<DEPTH.
  - cpu_we has priority: with both cpu_we and cpu_re high, cpu_re is ignored.
- Load (cpu_re=1, cpu_we=0):
  - Forward hit (newest entry whose word address matches, including the in-flight head): cpu_rdata = that entry's data combinationally; stall=0; zero latency.
  - Miss, load_done=0: stall=1.
    - Read is issued when the FSM reaches IDLE; an in-flight write is never interrupted.
    - Reads bypass queued stores; the address is known not to match any of them.
    - On mem_ack: capture mem_rdata into rdata_q and set load_done.
  - Miss, load_done=1: stall=0 and cpu_rdata=rdata_q; load_done clears at that edge.
  - Miss latency: ≥ mem latency + 1 cycle.
- FSM:
  - IDLE: pending miss → READ (mem_req=1, mem_we=0, mem_addr=cpu_addr). Otherwise, count>0 → WRITE (mem_req=1, mem_we=1, head entry on mem_addr/mem_wdata). Otherwise stay IDLE.
  - WRITE: hold mem_req and all mem_* stable until mem_ack. On mem_ack, dequeue head (count-1, head+1 mod DEPTH) and go to IDLE; mem_req=0 for at least one cycle.
  - READ: hold mem_req until mem_ack, then go to IDLE.
  - Load misses have priority over draining in IDLE.
- Simultaneous enqueue and dequeue in one cycle (count<DEPTH): count unchanged.
- Head and tail pointers wrap modulo DEPTH.
- wb_empty = (count==0) && FSM==IDLE.
- cpu_rdata is 0 when neither a forward nor a load_done is active.

Optional Feature:
- Macro: WB_COALESCE_EN.
- Defined: a store whose word address matches the newest pending entry that is NOT the in-flight head overwrites that entry's data in place. No allocation; count unchanged; no stall even when full.
- Undefined: every store allocates a new entry; a duplicate address when full stalls.

Test Plan:
- Reset then idle → wb_empty=1, wb_count=0, mem_req=0, stall=0.
- Store 0x100←0xDEADBEEF, mem_ack 3 cycles after req → mem_req/mem_we=1, mem_addr=0x100, mem_wdata=0xDEADBEEF held until ack; wb_count 1→0.
- Fill with DEPTH=4 stores, mem_ack withheld; fifth store to 0x200 → stall=1 until first ack; then 0x200 enqueued, wb_count=4.
- Store 0x104←0x11 then 0x104←0x22, then load 0x104 → cpu_rdata=0x22, stall=0. With WB_COALESCE_EN, wb_count=1 if the first entry is not in flight.
- Load miss 0x300 during an in-flight write; mem_rdata=0xCAFEF00D → read issued only after the write ack; stall drops one cycle after read ack; cpu_rdata=0xCAFEF00D.
- Assert rst during WRITE with mem_ack pending → next cycle mem_req=0, wb_count=0; a later mem_ack has no effect.
